// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings and helpers for the memory access unit
package mem_pkg;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10} op_e;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;
  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store byte-enable/replication and load lane extract with sign/zero extension
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                  size_i,
  input  logic                        unsigned_i,
  input  logic [$clog2(DATA_W/8)-1:0] offset_i,
  input  logic [DATA_W-1:0]           sdata_i,
  input  logic [DATA_W-1:0]           rdata_i,
  output logic [DATA_W/8-1:0]         be_o,
  output logic [DATA_W-1:0]           wdata_o,
  output logic [DATA_W-1:0]           ldata_o
);
  localparam int BW = DATA_W / 8;
  logic [3:0]        nb;
  logic [BW-1:0]     be_mask;
  logic [BW-1:0]     sign_bits;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] low_mask;
  logic              sign;
  always_comb begin
    nb = size_bytes(size_i);
    shifted = rdata_i >> {offset_i, 3'b000};
    be_mask = '0;
    sign_bits = '0;
    low_mask = '0;
    wdata_o = '0;
    for (int i = 0; i < BW; i++) begin
      be_mask[i] = 4'(i) < nb;
      low_mask[8*i +: 8] = {8{4'(i) < nb}};
      sign_bits[i] = shifted[8*i+7] & (4'(i) == nb - 4'd1);
      // source byte index wraps at the access size so small stores fill every lane
      wdata_o[8*i +: 8] = (size_i == SZ_B) ? sdata_i[7:0] :
                          (size_i == SZ_H) ? sdata_i[8*(i%2) +: 8] :
                          (size_i == SZ_W) ? sdata_i[8*(i%4) +: 8] : sdata_i[8*i +: 8];
    end
    be_o = be_mask << offset_i;
    sign = ~unsigned_i & (|sign_bits);
    ldata_o = (shifted & low_mask) | ({DATA_W{sign}} & ~low_mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage access controller with sized req/ack handshake, alignment check and timeout
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                valid_i,
  input  logic [1:0]          op_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic                stall_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   data_o,
  output logic                misalign_o,
  output logic                timeout_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);
  localparam int BW = DATA_W / 8;
  localparam int OW = $clog2(BW);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] TMAX = (CW+1)'(TIMEOUT);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q, we_q, req_q, mis_q, to_q;
  logic [DATA_W-1:0] sdata_q, data_q;
  logic [CW-1:0]     cnt_q;
  logic              mem_op, accept, illegal, hit;
  logic [3:0]        nb;
  logic [BW-1:0]     be;
  logic [DATA_W-1:0] wdata, ldata;
  assign mem_op  = valid_i && (op_i == OP_LOAD || op_i == OP_STORE);
  assign accept  = mem_op && state_q != S_REQ;
  assign nb      = size_bytes(size_i);
  assign illegal = (size_i == SZ_D && DATA_W != 64) || ((4'(address_i[2:0]) & (nb - 4'd1)) != 4'd0);
  assign hit     = TIMEOUT != 0 && ({1'b0, cnt_q} + 1'b1) == TMAX;
  assign data_o  = data_q;
  mem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .offset_i  (addr_q[OW-1:0]),
    .sdata_i   (sdata_q),
    .rdata_i   (mem_rdata_i),
    .be_o      (be),
    .wdata_o   (wdata),
    .ldata_o   (ldata)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == S_REQ) ? ((mem_ack_i || hit) ? S_DONE : S_REQ) :
              accept ? (illegal ? S_DONE : S_REQ) : S_IDLE;
  end
  always_comb begin
    stall_o     = state_q == S_REQ || (state_q == S_IDLE && mem_op);
    done_o      = state_q == S_DONE;
    misalign_o  = done_o && mis_q;
    timeout_o   = done_o && to_q;
    mem_req_o   = req_q;
    mem_we_o    = req_q && we_q;
    mem_addr_o  = req_q ? {addr_q[ADDR_W-1:OW], {OW{1'b0}}} : '0;
    mem_be_o    = req_q ? (we_q ? be : '1) : '0;
    mem_wdata_o = (req_q && we_q) ? wdata : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      sdata_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      req_q <= state_d == S_REQ;
      if (accept) begin
        addr_q  <= address_i;
        size_q  <= size_i;
        uns_q   <= unsigned_i;
        sdata_q <= data_i;
        we_q    <= op_i == OP_STORE;
        mis_q   <= illegal;
        to_q    <= 1'b0;
        cnt_q   <= '0;
      end
      if (state_q == S_REQ) begin
        cnt_q <= cnt_q + 1'b1;
        to_q  <= !mem_ack_i && hit;
        // ack wins over a timeout landing in the same cycle
        if (!we_q && mem_ack_i) data_q <= ldata;
        else if (!we_q && hit)  data_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for 32-bit (TIMEOUT=4) and 64-bit instances
module tb_mem_access_unit;
  import mem_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic        valid = 0, uns = 0, ack = 0;
  logic [1:0]  op = 0, size = 0;
  logic [31:0] addr = 0, din = 0, rdata = 0;
  logic        stall, done, mis, tout, req, we;
  logic [31:0] dout, maddr, mwdata;
  logic [3:0]  be;
  logic        v64 = 0, uns64 = 0, ack64 = 0;
  logic [1:0]  op64 = 0, size64 = 0;
  logic [31:0] addr64 = 0;
  logic [63:0] din64 = 0, rdata64 = 0;
  logic        stall64, done64, mis64, tout64, req64, we64;
  logic [63:0] dout64, mwdata64;
  logic [31:0] maddr64;
  logic [7:0]  be64;
  int n_chk = 0, n_fail = 0;
  int dcyc, reqs, stalls;
  logic stall0, we_s, mis_s, to_s;
  logic [3:0] be_s;
  logic [31:0] addr_s, wd_s;
  logic d64_s, we64_s;
  logic [7:0] be64_s;
  logic [31:0] addr64_s;
  logic [63:0] wd64_s;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid), .op_i(op), .size_i(size), .unsigned_i(uns),
    .address_i(addr), .data_i(din), .stall_o(stall), .done_o(done), .data_o(dout),
    .misalign_o(mis), .timeout_o(tout), .mem_req_o(req), .mem_we_o(we), .mem_addr_o(maddr),
    .mem_wdata_o(mwdata), .mem_be_o(be), .mem_ack_i(ack), .mem_rdata_i(rdata)
  );
  mem_access_unit #(.ADDR_W(32), .DATA_W(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .valid_i(v64), .op_i(op64), .size_i(size64), .unsigned_i(uns64),
    .address_i(addr64), .data_i(din64), .stall_o(stall64), .done_o(done64), .data_o(dout64),
    .misalign_o(mis64), .timeout_o(tout64), .mem_req_o(req64), .mem_we_o(we64), .mem_addr_o(maddr64),
    .mem_wdata_o(mwdata64), .mem_be_o(be64), .mem_ack_i(ack64), .mem_rdata_i(rdata64)
  );

  // drive one op on the 32-bit unit, scramble inputs after accept, ack in REQ cycle ack_at (0 = never)
  task automatic run_op(input logic [1:0] o, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] d, input int ack_at, input logic [31:0] rd);
    @(negedge clk);
    valid = 1; op = o; size = sz; uns = u; addr = a; din = d; ack = 0; rdata = rd;
    #1 stall0 = stall;
    @(negedge clk);
    valid = 0; size = ~sz; uns = ~u; addr = '1; din = 32'h5A5A_5A5A;
    reqs = 0; stalls = 0; dcyc = -1; be_s = 0; addr_s = 0; wd_s = 0; we_s = 0; mis_s = 0; to_s = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        dcyc = c; mis_s = mis; to_s = tout;
        break;
      end
      if (req) begin
        if (reqs == 0) begin be_s = be; addr_s = maddr; wd_s = mwdata; we_s = we; end
        reqs++;
      end
      if (stall) stalls++;
      ack = req && reqs == ack_at;
      @(negedge clk);
      ack = 0;
    end
  endtask

  // one op on the 64-bit unit with ack in the first REQ cycle; returns at the DONE negedge
  task automatic run64(input logic [1:0] o, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [63:0] d, input logic [63:0] rd);
    @(negedge clk);
    v64 = 1; op64 = o; size64 = sz; uns64 = u; addr64 = a; din64 = d;
    @(negedge clk);
    v64 = 0; be64_s = be64; addr64_s = maddr64; wd64_s = mwdata64; we64_s = we64;
    ack64 = 1; rdata64 = rd;
    @(negedge clk);
    ack64 = 0; d64_s = done64;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({stall, done, mis, tout, req, we, maddr, be, mwdata, dout} !== '0) begin
      n_fail++; $display("FAIL reset32: outputs not zero, got done=%b req=%b data=%h", done, req, dout);
    end
    n_chk++;
    if ({stall64, done64, mis64, tout64, req64, we64, maddr64, be64, mwdata64, dout64} !== '0) begin
      n_fail++; $display("FAIL reset64: outputs not zero, got done=%b req=%b data=%h", done64, req64, dout64);
    end
    reset_n = 1;
  endtask

  task automatic test_load_word;
    run_op(OP_LOAD, SZ_W, 0, 32'h100, 0, 4, 32'hDEAD_BEEF);
    n_chk++; if (stall0 !== 1'b1) begin n_fail++; $display("FAIL lw_stall_accept: got %b expected 1", stall0); end
    n_chk++; if (dcyc != 5) begin n_fail++; $display("FAIL lw_done_cycle: got %0d expected 5", dcyc); end
    n_chk++; if (dout !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data: got %h expected deadbeef", dout); end
    n_chk++; if (be_s !== 4'hF) begin n_fail++; $display("FAIL lw_be: got %h expected f", be_s); end
    n_chk++; if (addr_s !== 32'h100 || we_s !== 1'b0) begin n_fail++; $display("FAIL lw_addr_we: got %h/%b expected 100/0", addr_s, we_s); end
    n_chk++; if (stalls != 4) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d expected 4", stalls); end
    n_chk++; if (stall !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL lw_done_state: stall=%b req=%b expected 0/0", stall, req); end
  endtask

  task automatic test_sign_ext;
    run_op(OP_LOAD, SZ_B, 0, 32'h103, 0, 1, 32'h8012_3456);
    n_chk++; if (dout !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_signed: got %h expected ffffff80", dout); end
    n_chk++; if (dcyc != 2) begin n_fail++; $display("FAIL lb_min_latency: got %0d expected 2", dcyc); end
    run_op(OP_LOAD, SZ_B, 1, 32'h103, 0, 1, 32'h8012_3456);
    n_chk++; if (dout !== 32'h0000_0080) begin n_fail++; $display("FAIL lb_unsigned: got %h expected 00000080", dout); end
  endtask

  task automatic test_store_half;
    run_op(OP_STORE, SZ_H, 0, 32'h202, 32'h0000_ABCD, 2, 32'hFFFF_FFFF);
    n_chk++; if (addr_s !== 32'h200) begin n_fail++; $display("FAIL sh_addr: got %h expected 200", addr_s); end
    n_chk++; if (be_s !== 4'hC) begin n_fail++; $display("FAIL sh_be: got %h expected c", be_s); end
    n_chk++; if (wd_s !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h expected abcdabcd", wd_s); end
    n_chk++; if (we_s !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b expected 1", we_s); end
    n_chk++; if (dout !== 32'h0000_0080 || dcyc != 3) begin n_fail++; $display("FAIL sh_data_kept: got %h cyc %0d expected 00000080 cyc 3", dout, dcyc); end
  endtask

  task automatic test_misalign;
    run_op(OP_LOAD, SZ_W, 0, 32'h101, 0, 1, 32'h1234_5678);
    n_chk++; if (dcyc != 1 || mis_s !== 1'b1) begin n_fail++; $display("FAIL mis_word: cyc %0d mis %b expected 1/1", dcyc, mis_s); end
    n_chk++; if (reqs != 0) begin n_fail++; $display("FAIL mis_no_req: got %0d req cycles expected 0", reqs); end
    n_chk++; if (dout !== 32'h0000_0080) begin n_fail++; $display("FAIL mis_data_kept: got %h expected 00000080", dout); end
    n_chk++; if (stall0 !== 1'b1) begin n_fail++; $display("FAIL mis_stall: got %b expected 1", stall0); end
    run_op(OP_LOAD, SZ_D, 0, 32'h0, 0, 1, 32'h1234_5678);
    n_chk++; if (mis_s !== 1'b1 || reqs != 0) begin n_fail++; $display("FAIL mis_dword32: mis %b reqs %0d expected 1/0", mis_s, reqs); end
    run_op(OP_LOAD, SZ_H, 0, 32'h102, 0, 1, 32'hABCD_0000);
    n_chk++; if (mis_s !== 1'b0 || dout !== 32'hFFFF_ABCD) begin n_fail++; $display("FAIL lh_aligned: mis %b data %h expected 0/ffffabcd", mis_s, dout); end
  endtask

  task automatic test_timeout;
    run_op(OP_LOAD, SZ_W, 0, 32'h40, 0, 0, 32'h0000_0055);
    n_chk++; if (dcyc != 5 || reqs != 4) begin n_fail++; $display("FAIL to_cycles: cyc %0d reqs %0d expected 5/4", dcyc, reqs); end
    n_chk++; if (to_s !== 1'b1 || mis_s !== 1'b0) begin n_fail++; $display("FAIL to_flag: to %b mis %b expected 1/0", to_s, mis_s); end
    n_chk++; if (dout !== 32'h0) begin n_fail++; $display("FAIL to_data: got %h expected 0", dout); end
    @(negedge clk);
    n_chk++; if (tout !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL to_pulse: to %b done %b expected 0/0", tout, done); end
  endtask

  task automatic test_reset_mid_req;
    run_op(OP_LOAD, SZ_W, 0, 32'h100, 0, 1, 32'h1111_1111);
    @(negedge clk);
    valid = 1; op = OP_LOAD; size = SZ_W; uns = 0; addr = 32'h20;
    @(negedge clk);
    valid = 0;
    n_chk++; if (req !== 1'b1) begin n_fail++; $display("FAIL rst_req_before: got %b expected 1", req); end
    @(negedge clk);
    reset_n = 0;
    #1;
    n_chk++; if (req !== 1'b0 || dout !== 32'h0) begin n_fail++; $display("FAIL rst_async: req %b data %h expected 0/0", req, dout); end
    @(negedge clk);
    reset_n = 1; ack = 1; rdata = 32'hCAFE_F00D;
    @(negedge clk);
    ack = 0;
    n_chk++; if (done !== 1'b0 || dout !== 32'h0 || req !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack: done %b data %h req %b expected 0/0/0", done, dout, req); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    valid = 1; op = OP_LOAD; size = SZ_W; uns = 0; addr = 32'h30;
    @(negedge clk);
    valid = 0; ack = 1; rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    ack = 0;
    n_chk++; if (done !== 1'b1 || dout !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL b2b_first: done %b data %h expected 1/a5a5a5a5", done, dout); end
    valid = 1; op = OP_LOAD; size = SZ_H; uns = 1; addr = 32'h32;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done_stall: got %b expected 0", stall); end
    @(negedge clk);
    valid = 0;
    n_chk++; if (req !== 1'b1 || done !== 1'b0 || maddr !== 32'h30) begin n_fail++; $display("FAIL b2b_second_req: req %b done %b addr %h expected 1/0/30", req, done, maddr); end
    ack = 1; rdata = 32'h8001_0000;
    @(negedge clk);
    ack = 0;
    n_chk++; if (done !== 1'b1 || dout !== 32'h0000_8001) begin n_fail++; $display("FAIL b2b_second: done %b data %h expected 1/00008001", done, dout); end
  endtask

  task automatic test_wide64;
    run64(OP_LOAD, SZ_D, 0, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF);
    n_chk++; if (be64_s !== 8'hFF || addr64_s !== 32'h8) begin n_fail++; $display("FAIL d64_req: be %h addr %h expected ff/8", be64_s, addr64_s); end
    n_chk++; if (d64_s !== 1'b1 || dout64 !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL d64_data: done %b data %h expected 1/0123456789abcdef", d64_s, dout64); end
    run64(OP_LOAD, SZ_B, 0, 32'hD, 64'h0, 64'h1122_8344_5566_7788);
    n_chk++; if (dout64 !== 64'hFFFF_FFFF_FFFF_FF83) begin n_fail++; $display("FAIL b64_signed: got %h expected ffffffffffffff83", dout64); end
    run64(OP_STORE, SZ_W, 0, 32'hC, 64'h0000_0000_CAFE_BABE, 64'h0);
    n_chk++; if (be64_s !== 8'hF0 || addr64_s !== 32'h8 || we64_s !== 1'b1) begin n_fail++; $display("FAIL sw64_req: be %h addr %h we %b expected f0/8/1", be64_s, addr64_s, we64_s); end
    n_chk++; if (wd64_s !== 64'hCAFE_BABE_CAFE_BABE) begin n_fail++; $display("FAIL sw64_wdata: got %h expected cafebabecafebabe", wd64_s); end
    n_chk++; if (dout64 !== 64'hFFFF_FFFF_FFFF_FF83) begin n_fail++; $display("FAIL sw64_data_kept: got %h expected ffffffffffffff83", dout64); end
  endtask

  initial begin
    test_reset;
    test_load_word;
    test_sign_ext;
    test_store_half;
    test_misalign;
    test_timeout;
    test_reset_mid_req;
    test_back_to_back;
    test_wide64;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised memory-stage access controller, successor to the fixed-word MEM stage.
- Sits between the pipeline MEM stage and the cache/memory port.
- Adds byte/halfword/word(/doubleword) sizes, store byte-enables, sign/zero extension and alignment checking.
- Uses a multi-cycle req/ack handshake with stall and a timeout guard.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data/port width; legal values 32 or 64.
- TIMEOUT, 255, max cycles waiting for mem_ack_i; 0 disables the timeout.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- valid_i  input  1  op present from pipeline.
- op_i  input  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
- size_i  input  2  00 byte, 01 half, 10 word, 11 dword (legal only if DATA_W=64).
- unsigned_i  input  1  load zero-extend when 1, sign-extend when 0.
- address_i  input  ADDR_W  byte address.
- data_i  input  DATA_W  store data, right-aligned.
- stall_o  output  1  pipeline must hold inputs.
- done_o  output  1  one-cycle completion pulse.
- data_o  output  DATA_W  registered, extended load result.
- misalign_o  output  1  one-cycle pulse: illegal size or misaligned address.
- timeout_o  output  1  one-cycle pulse: no ack within TIMEOUT.
- mem_req_o  output  1  request to memory.
- mem_we_o  output  1  1 = write.
- mem_addr_o  output  ADDR_W  address aligned to DATA_W/8, low bits zero.
- mem_wdata_o  output  DATA_W  store data replicated across lanes.
- mem_be_o  output  DATA_W/8  byte enables; all ones on reads.
- mem_ack_i  input  1  memory accepted write / read data valid.
- mem_rdata_i  input  DATA_W  full-width read data, valid with ack.

Behaviour:
- Reset (async assert, sync deassert by design):
  - state IDLE; timeout counter cleared.
  - All outputs 0, including data_o.
  - An in-flight request is dropped immediately; a later ack is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - Op accepted when valid_i=1 and op_i is 01/10.
  - Illegal op (size 11 with DATA_W=32, or address not a multiple of the access size) -> next cycle misalign_o=1 and done_o=1 in DONE, no memory access, data_o unchanged.
  - Legal op -> latch address/size/unsigned/data/op, go to REQ.
  - stall_o is combinational: 1 in IDLE whenever valid_i and op is 01/10, including illegal ops, until DONE.
- REQ:
  - Registered mem_req_o=1, mem_we_o=op==store, held stable until mem_ack_i.
  - stall_o=1.
  - Counter increments every REQ cycle.
  - mem_ack_i=1 -> capture lane, update data_o on loads only, go to DONE.
  - Ack in the first REQ cycle is legal, giving minimum latency of 2 cycles from accept to done_o.
  - Counter reaches TIMEOUT with no ack -> deassert req, timeout_o=1 in DONE, data_o forced to 0 for loads.
- DONE:
  - done_o=1 and stall_o=0 for exactly one cycle; mem_req_o=0.
  - A new valid op in DONE is evaluated as in IDLE (back-to-back).
  - Otherwise return to IDLE.
- Lane rules: offset = address mod DATA_W/8.
  - mem_be_o = size mask (1,3,F,FF) << offset.
  - mem_wdata_o = low size bytes of data_i replicated to fill DATA_W.
  - Load = mem_rdata_i >> (8*offset), truncated to size, extended per unsigned_i.
  - Full-width access ignores unsigned_i.
- mem_ack_i outside REQ is ignored.
- Inputs change while stall_o=1 have no effect; latched copies are used.

Decomposition:
- Shared package mem_pkg:
  - op encodings (OP_NONE/LOAD/STORE).
  - size encodings (SZ_B/H/W/D).
  - state enum.
  - function size_bytes(size).
- Natural sub-module: mem_lane_align (combinational) — be/wdata generation and load extract/extend.
- FSM and counter stay in the top.

Test Plan:
- Load word, addr 0x100, ack after 3 REQ cycles, rdata 0xDEADBEEF -> done_o on cycle 5 after accept, data_o=0xDEADBEEF, be=0xF, stall_o high 4 cycles.
- Signed byte load, addr 0x103, rdata 0x80123456, unsigned_i=0 -> data_o=0xFFFFFF80; same with unsigned_i=1 -> 0x00000080.
- Halfword store, addr 0x202, data_i 0x0000ABCD -> mem_addr_o=0x200, be=0xC, wdata=0xABCDABCD, we=1.
- Word load at 0x101 -> misalign_o and done_o pulse next cycle, mem_req_o never asserted, data_o unchanged.
- TIMEOUT=4, no ack -> req drops after 4 REQ cycles, timeout_o=1, data_o=0; reset_n low mid-REQ -> mem_req_o 0 immediately, late ack ignored.
- Back-to-back: second load presented in DONE with ack in the first REQ cycle -> done_o pulses every 2 cycles; DATA_W=64 dword load at 0x8 -> be=0xFF.
